// File: rtl/dac_spi_out.sv
// dac_spi_out: serial DAC driver fed from the modulator output.
//
// Takes one signed sample on each sample_valid strobe. The sample is truncated to DAC_WIDTH
// bits and, optionally, converted to offset binary. The result is shifted MSB-first to an SPI
// DAC using mode 0 (SCLK idles low and the DAC samples on the rising edge). A single-entry
// holding register sits between the strobe and the frame timing. If a held sample is replaced
// before it is sent, the event is flagged and counted.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   sample_in      signed two's-complement sample, IN_WIDTH bits
//   sample_valid   one-cycle strobe qualifying sample_in
//   clr_overrun    synchronous clear of overrun_cnt
//   dac_sclk       SPI clock, idles low
//   dac_mosi       SPI data, MSB first
//   dac_cs_n       SPI chip select, active low
//   busy           frame in progress or holding register full
//   overrun        one-cycle pulse when a held sample is overwritten
//   overrun_cnt    saturating count of overwrites
module dac_spi_out #(
    parameter int unsigned IN_WIDTH      = 32,
    parameter int unsigned DAC_WIDTH     = 16,
    parameter int unsigned SCLK_DIV      = 2,
    parameter int unsigned CS_IDLE       = 2,
    parameter bit          OFFSET_BINARY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                clr_overrun,
    output logic                dac_sclk,
    output logic                dac_mosi,
    output logic                dac_cs_n,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         overrun_cnt
);

    localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);
    localparam int unsigned GAP_W = $clog2(CS_IDLE + 1);
    localparam int unsigned BIT_W = $clog2(DAC_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [DAC_WIDTH-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DAC_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 transfer;

    // Truncate to the top DAC_WIDTH bits. Offset binary only flips the sign bit.
    logic [DAC_WIDTH-1:0] code_raw;
    logic [DAC_WIDTH-1:0] code;

    assign code_raw = sample_in[IN_WIDTH-1 -: DAC_WIDTH];

    always_comb begin
        code = code_raw;
        if (OFFSET_BINARY) begin
            code[DAC_WIDTH-1] = ~code_raw[DAC_WIDTH-1];
        end
    end

    // Discarded low-order sample bits.
    if (IN_WIDTH > DAC_WIDTH) begin : g_unused_low
        logic unused_low;
        assign unused_low = ^sample_in[IN_WIDTH-DAC_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        div_d       = div_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        overrun_d   = 1'b0;
        cnt_d       = cnt_q;
        transfer    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                transfer    = 1'b1;
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                cs_n_d      = 1'b0;
                sclk_d      = 1'b0;
                mosi_d      = hold_q[DAC_WIDTH-1];
                div_d       = '0;
                bit_d       = '0;
                state_d     = StShift;
            end

            StShift: begin
                if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_W'(DAC_WIDTH - 1)) begin
                            // The last high phase closes the frame.
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            gap_d   = '0;
                            state_d = StGap;
                        end else begin
                            // Falling edge: present the next bit for the following rise.
                            bit_d   = bit_q + 1'b1;
                            shift_d = shift_q << 1;
                            mosi_d  = shift_q[DAC_WIDTH-2];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StGap: begin
                if (gap_q == GAP_W'(CS_IDLE - 1)) begin
                    state_d = hold_full_q ? StLoad : StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase

        // A strobe always lands in the holding register. It counts as an overrun only when
        // the previous code is still waiting there and is not being moved out this cycle.
        if (sample_valid) begin
            if (hold_full_q && !transfer) begin
                overrun_d = 1'b1;
            end
            hold_d      = code;
            hold_full_d = 1'b1;
        end

        if (clr_overrun) begin
            cnt_d = overrun_d ? 16'd1 : 16'd0;
        end else if (overrun_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        busy_d = (state_d != StIdle) | hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dac_sclk    = sclk_q;
    assign dac_mosi    = mosi_q;
    assign dac_cs_n    = cs_n_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// Testbench for dac_spi_out: each issued sample pushes its expected DAC code, and the SPI
// monitor decodes every frame and compares it against the head of the queue.
module tb_dac_spi_out;

    localparam int unsigned CS_IDLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_cs_n;
    logic        busy;
    logic        overrun;
    logic [15:0] overrun_cnt;

    always #5 clk = ~clk;

    dac_spi_out #(
        .IN_WIDTH     (32),
        .DAC_WIDTH    (16),
        .SCLK_DIV     (2),
        .CS_IDLE      (CS_IDLE),
        .OFFSET_BINARY(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clr_overrun (clr_overrun),
        .dac_sclk    (dac_sclk),
        .dac_mosi    (dac_mosi),
        .dac_cs_n    (dac_cs_n),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    bit          mon_en = 1'b1;
    bit          chk_gap = 1'b0;
    int          ov_seen = 0;
    int          gap_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is just after a falling clk edge; the strobe is sampled on the next rising edge.
    task automatic issue(input logic [31:0] s, input logic [15:0] e, input bit push);
        sample_in    = s;
        sample_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && dac_cs_n) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    // SPI monitor
    initial begin : monitor
        logic        prev_cs;
        logic        prev_sclk;
        logic        in_frame;
        logic [15:0] data;
        logic [15:0] e;
        int          nbits;
        int          low_cyc;
        int          high_cyc;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        in_frame  = 1'b0;
        data      = '0;
        nbits     = 0;
        low_cyc   = 0;
        high_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame  = 1'b0;
                prev_cs   = 1'b1;
                prev_sclk = 1'b0;
                high_cyc  = 0;
            end else begin
                if (overrun) ov_seen++;
                if (prev_cs && !dac_cs_n) begin
                    if (chk_gap) begin
                        check("cs_high_gap", 32'(high_cyc), 32'(CS_IDLE + 1));
                        gap_checks++;
                    end
                    in_frame = 1'b1;
                    nbits    = 0;
                    low_cyc  = 0;
                    data     = '0;
                end
                if (!dac_cs_n) begin
                    low_cyc++;
                    high_cyc = 0;
                    if (!prev_sclk && dac_sclk) begin
                        data = {data[14:0], dac_mosi};
                        nbits++;
                    end
                end else begin
                    high_cyc++;
                    if (!prev_cs && in_frame) begin
                        in_frame = 1'b0;
                        if (mon_en) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL frame_unexpected: got frame %h, expected none",
                                         data);
                            end else begin
                                e = exp_q.pop_front();
                                check("frame_data", 32'(data), 32'(e));
                                check("frame_sclk_rises", 32'(nbits), 32'd16);
                                check("cs_low_cycles", 32'(low_cyc), 32'd64);
                            end
                        end
                    end
                end
                prev_cs   = dac_cs_n;
                prev_sclk = dac_sclk;
            end
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] t2_in [4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [15:0] t2_exp[4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h9234};
    logic [31:0] t3_in [10] = '{32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0001, 32'hC000_0000,
                                32'h4000_1234, 32'hFFFE_0000, 32'h5555_AAAA, 32'hAAAA_5555,
                                32'h0F0F_0000, 32'hF0F0_FFFF};
    logic [15:0] t3_exp[10] = '{16'h8001, 16'hFFFF, 16'h0000, 16'h4000, 16'hC000,
                                16'h7FFE, 16'hD555, 16'h2AAA, 16'h8F0F, 16'h70F0};

    initial begin : stimulus
        int ov0;
        int edges;
        logic prev;
        bit found;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_mosi", 32'(dac_mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all-ones frame and strobe-to-CS latency
        issue(32'h7FFF_0000, 16'hFFFF, 1'b1);
        check("busy_after_valid", 32'(busy), 32'd1);
        check("cs_n_t0", 32'(dac_cs_n), 32'd1);
        @(negedge clk);
        check("cs_n_t1", 32'(dac_cs_n), 32'd1);
        @(negedge clk);
        check("cs_n_t2", 32'(dac_cs_n), 32'd0);
        drain();

        // 2: code mapping
        for (int i = 0; i < 4; i++) begin
            issue(t2_in[i], t2_exp[i], 1'b1);
            drain();
        end

        // 3: back-to-back frames at the natural frame period
        ov0 = ov_seen;
        gap_checks = 0;
        for (int i = 0; i < 10; i++) begin
            issue(t3_in[i], t3_exp[i], 1'b1);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                chk_gap = 1'b1;
                repeat (63) @(negedge clk);
            end else begin
                repeat (66) @(negedge clk);
            end
        end
        drain();
        chk_gap = 1'b0;
        check("t3_gap_checks", 32'(gap_checks), 32'd9);
        check("t3_overrun_pulses", 32'(ov_seen - ov0), 32'd0);
        check("t3_overrun_cnt", 32'(overrun_cnt), 32'd0);

        // 4: A, B, C ten cycles apart; C overwrites B while A is still shifting
        ov0 = ov_seen;
        issue(32'h1111_0000, 16'h9111, 1'b1);
        repeat (9) @(negedge clk);
        issue(32'h2222_0000, 16'h0000, 1'b0);
        repeat (9) @(negedge clk);
        issue(32'h3333_0000, 16'hB333, 1'b1);
        drain();
        check("t4_overrun_pulses", 32'(ov_seen - ov0), 32'd1);
        check("t4_overrun_cnt", 32'(overrun_cnt), 32'd1);

        // 5: reset in mid-frame
        issue(32'h6000_0000, 16'h0000, 1'b0);
        edges = 0;
        prev  = dac_sclk;
        for (int i = 0; i < 200 && edges < 5; i++) begin
            @(negedge clk);
            if (!prev && dac_sclk) edges++;
            prev = dac_sclk;
        end
        check("t5_sclk_rises", 32'(edges), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("t5_rst_sclk", 32'(dac_sclk), 32'd0);
        check("t5_rst_mosi", 32'(dac_mosi), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_cs_n", 32'(dac_cs_n), 32'd1);
        issue(32'h0123_4567, 16'h8123, 1'b1);
        drain();

        // 6: overrun counter saturation and clear
        mon_en       = 1'b0;
        sample_in    = 32'h1000_0000;
        sample_valid = 1'b1;
        repeat (67500) @(negedge clk);
        check("t6_cnt_saturated", 32'(overrun_cnt), 32'h0000_FFFF);
        repeat (100) @(negedge clk);
        check("t6_cnt_held", 32'(overrun_cnt), 32'h0000_FFFF);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dac_sclk) found = 1'b1;
        end
        check("t6_find_shift", 32'(found), 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun  = 1'b0;
        sample_valid = 1'b0;
        check("t6_clr_with_overrun", 32'(overrun_cnt), 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("t6_clr", 32'(overrun_cnt), 32'd0);
        drain();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Normal operation after saturation
        issue(32'hFEDC_BA98, 16'h7EDC, 1'b1);
        drain();
        check("final_overrun_cnt", 32'(overrun_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
